// File: rtl/board_ctrl_pkg.sv
// Shared definitions for the board control register slave: register offsets,
// field reset values, bus types and the regbus FSM state encoding.
package board_ctrl_pkg;

  // Word index (address bits [4:2]) of each register
  localparam logic [2:0] OffScratch = 3'd0;
  localparam logic [2:0] OffRtcHalf = 3'd1;
  localparam logic [2:0] OffFanCtrl = 3'd2;
  localparam logic [2:0] OffBoot    = 3'd3;
  localparam logic [2:0] OffStatus  = 3'd4;

  // FAN_CTRL reset: duty 0xF, switch select enabled
  localparam logic [4:0]  FanCtrlRst = 5'h1F;
  // Read data returned for unmapped offsets
  localparam logic [31:0] BadVal     = 32'hBADCAB1E;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // Default regbus types (48-bit address)
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [47:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } regbus_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } regbus_rsp_t;

  // Byte-wise merge of write data into the current register value
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/board_pwm_gen.sv
// Fan PWM generator: prescaler, 16-slot counter and registered duty compare.
module board_pwm_gen #(
  parameter int unsigned Prescale = 125
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] duty_i,
  output logic       pwm_o
);

  localparam int unsigned PreW = (Prescale > 1) ? $clog2(Prescale) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(Prescale - 1);

  logic [PreW-1:0] pre_q;
  logic [3:0]      slot_q;
  logic            pwm_q;

  // Prescaler wraps at Prescale-1 and advances the slot counter (15 -> 0)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q  <= '0;
      slot_q <= '0;
    end else if (pre_q == PreMax) begin
      pre_q  <= '0;
      slot_q <= slot_q + 4'd1;
    end else begin
      pre_q  <= pre_q + 1'b1;
    end
  end

  // Output is high while the slot index is below the duty value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= (slot_q < duty_i);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/sync.sv
// Multi-stage flop synchronizer for a single asynchronous bit.
module sync #(
  parameter int unsigned STAGES     = 2,
  parameter bit          ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic serial_i,
  output logic serial_o
);

  logic [STAGES-1:0] reg_q;

  // Shift the input through the synchronizer chain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_q <= {STAGES{ResetValue}};
    end else begin
      reg_q <= {reg_q[STAGES-2:0], serial_i};
    end
  end

  assign serial_o = reg_q[STAGES-1];

endmodule

// File: rtl/board_ctrl_regs.sv
// Board control regbus slave: scratch, RTC tick generator, fan PWM control,
// boot-mode override and synchronized board status.
//
// Handshake: a request is taken in IDLE whenever valid=1; the registered
// response (ready=1, rdata, error) is presented for exactly one cycle in RESP.
// valid is not looked at in RESP. Outside RESP the response is all zero.
module board_ctrl_regs
  import board_ctrl_pkg::*;
#(
  parameter int unsigned AddrWidth   = 48,
  parameter type         reg_req_t   = regbus_req_t,
  parameter type         reg_rsp_t   = regbus_rsp_t,
  parameter logic [15:0] RtcHalfRst  = 16'd24,
  parameter int unsigned FanPrescale = 125
) (
  input  logic       soc_clk,
  input  logic       rst_n,
  input  reg_req_t   reg_req_i,
  output reg_rsp_t   reg_rsp_o,
  input  logic [3:0] fan_sw_i,
  input  logic [1:0] boot_mode_i,
  input  logic       dram_calib_i,
  output logic       rtc_o,
  output logic       fan_pwm_o,
  output logic [1:0] boot_mode_o,
  output state_e     dbg_state_o
);

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic [6:0] async_in;
  logic [6:0] async_s;
  logic [3:0] fan_sw_s;
  logic [1:0] boot_mode_s;
  logic       dram_calib_s;

  assign async_in = {dram_calib_i, boot_mode_i, fan_sw_i};

  for (genvar i = 0; i < 7; i++) begin : g_sync
    sync #(
      .STAGES     (2),
      .ResetValue (1'b0)
    ) i_sync (
      .clk_i    (soc_clk),
      .rst_ni   (rst_n),
      .serial_i (async_in[i]),
      .serial_o (async_s[i])
    );
  end

  assign fan_sw_s     = async_s[3:0];
  assign boot_mode_s  = async_s[5:4];
  assign dram_calib_s = async_s[6];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [AddrWidth-1:0] addr;
  logic [2:0]           word_idx;
  logic                 unused_addr;

  assign addr        = AddrWidth'(reg_req_i.addr);
  assign word_idx    = addr[4:2];
  assign unused_addr = ^{addr[AddrWidth-1:5], addr[1:0]};

  state_e state_q;
  logic   req_accept;
  logic   wr_en;

  assign req_accept = (state_q == IDLE) && reg_req_i.valid;
  assign wr_en      = req_accept && reg_req_i.write;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [31:0] scratch_q;
  logic [15:0] rtc_half_q;
  logic [3:0]  fan_duty_q;
  logic        fan_sw_sel_q;
  logic [2:0]  boot_q;
  logic        rtc_q;

  logic [31:0] rd_val;
  logic        rd_err;
  logic [31:0] wr_merged;

  // Read mux; unimplemented bits read as zero
  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    case (word_idx)
      OffScratch: rd_val = scratch_q;
      OffRtcHalf: rd_val = {16'b0, rtc_half_q};
      OffFanCtrl: rd_val = {27'b0, fan_sw_sel_q, fan_duty_q};
      OffBoot:    rd_val = {29'b0, boot_q};
      OffStatus:  rd_val = {24'b0, rtc_q, dram_calib_s, boot_mode_s, fan_sw_s};
      default: begin
        rd_val = BadVal;
        rd_err = 1'b1;
      end
    endcase
  end

  assign wr_merged = strb_merge(rd_val, reg_req_i.wdata, reg_req_i.wstrb);

  // Commit writes on the accepting edge; STATUS and unmapped offsets ignore them
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch_q    <= '0;
      rtc_half_q   <= RtcHalfRst;
      fan_duty_q   <= FanCtrlRst[3:0];
      fan_sw_sel_q <= FanCtrlRst[4];
      boot_q       <= '0;
    end else if (wr_en) begin
      case (word_idx)
        OffScratch: scratch_q  <= wr_merged;
        OffRtcHalf: rtc_half_q <= wr_merged[15:0];
        OffFanCtrl: begin
          fan_duty_q   <= wr_merged[3:0];
          fan_sw_sel_q <= wr_merged[4];
        end
        OffBoot:    boot_q     <= wr_merged[2:0];
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Regbus FSM with registered response
  // ---------------------------------------------------------------------------
  logic        rsp_ready_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_error_q;

  // Accept in IDLE, present the response for one cycle in RESP, then clear it
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_ready_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (reg_req_i.valid) begin
            state_q     <= RESP;
            rsp_ready_q <= 1'b1;
            rsp_rdata_q <= (reg_req_i.write && !rd_err) ? 32'b0 : rd_val;
            rsp_error_q <= rd_err;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_ready_q <= 1'b0;
          rsp_rdata_q <= '0;
          rsp_error_q <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          rsp_ready_q <= 1'b0;
          rsp_rdata_q <= '0;
          rsp_error_q <= 1'b0;
        end
      endcase
    end
  end

  // Drive the response struct from the registered fields
  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = rsp_ready_q;
    reg_rsp_o.rdata = rsp_rdata_q;
    reg_rsp_o.error = rsp_error_q;
  end

  assign dbg_state_o = state_q;

  // ---------------------------------------------------------------------------
  // RTC tick generator
  // ---------------------------------------------------------------------------
  logic [15:0] rtc_cnt_q;
  logic        rtc_wr;

  assign rtc_wr = wr_en && (word_idx == OffRtcHalf);

  // A write to RTC_HALF restarts the period and wins over a same-cycle match
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      rtc_cnt_q <= '0;
      rtc_q     <= 1'b0;
    end else if (rtc_wr) begin
      rtc_cnt_q <= '0;
      rtc_q     <= 1'b0;
    end else if (rtc_cnt_q == rtc_half_q) begin
      rtc_cnt_q <= '0;
      rtc_q     <= ~rtc_q;
    end else begin
      rtc_cnt_q <= rtc_cnt_q + 16'd1;
    end
  end

  assign rtc_o = rtc_q;

  // ---------------------------------------------------------------------------
  // Fan PWM and boot mode
  // ---------------------------------------------------------------------------
  logic [3:0] fan_duty_eff;

  assign fan_duty_eff = fan_sw_sel_q ? fan_sw_s : fan_duty_q;

  board_pwm_gen #(
    .Prescale (FanPrescale)
  ) i_pwm (
    .clk_i  (soc_clk),
    .rst_ni (rst_n),
    .duty_i (fan_duty_eff),
    .pwm_o  (fan_pwm_o)
  );

  logic [1:0] boot_mode_q;

  // Registered boot mode: override when enabled, otherwise the board switches
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_mode_q <= 2'b00;
    end else begin
      boot_mode_q <= boot_q[2] ? boot_q[1:0] : boot_mode_s;
    end
  end

  assign boot_mode_o = boot_mode_q;

endmodule

// File: tb/tb_board_ctrl_regs.sv
// Directed testbench for board_ctrl_regs.
module tb_board_ctrl_regs;
  import board_ctrl_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic soc_clk = 1'b0;
  logic rst_n   = 1'b0;

  always #5 soc_clk = ~soc_clk;

  regbus_req_t req;
  regbus_rsp_t rsp;
  logic [3:0]  fan_sw_i;
  logic [1:0]  boot_mode_i;
  logic        dram_calib_i;
  logic        rtc_o;
  logic        fan_pwm_o;
  logic [1:0]  boot_mode_o;
  state_e      dbg_state;

  board_ctrl_regs #(
    .AddrWidth   (48),
    .reg_req_t   (regbus_req_t),
    .reg_rsp_t   (regbus_rsp_t),
    .RtcHalfRst  (16'd24),
    .FanPrescale (125)
  ) dut (
    .soc_clk      (soc_clk),
    .rst_n        (rst_n),
    .reg_req_i    (req),
    .reg_rsp_o    (rsp),
    .fan_sw_i     (fan_sw_i),
    .boot_mode_i  (boot_mode_i),
    .dram_calib_i (dram_calib_i),
    .rtc_o        (rtc_o),
    .fan_pwm_o    (fan_pwm_o),
    .boot_mode_o  (boot_mode_o),
    .dbg_state_o  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One access: drive at a falling edge (cycle N), sample the response in N+1
  task automatic bus_access(input logic wr, input logic [47:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb,
                            output logic [31:0] rdata, output logic err);
    @(negedge soc_clk);
    req.valid = 1'b1;
    req.write = wr;
    req.addr  = addr;
    req.wdata = wdata;
    req.wstrb = wstrb;
    @(negedge soc_clk);
    chk("ready_n1", {31'b0, rsp.ready}, 32'd1);
    rdata = rsp.rdata;
    err   = rsp.error;
    req   = '0;
  endtask

  task automatic bus_write(input logic [47:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb);
    logic [31:0] rd;
    logic        er;
    bus_access(1'b1, addr, wdata, wstrb, rd, er);
  endtask

  task automatic read_chk(input string tag, input logic [47:0] addr,
                          input logic [31:0] mask, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    exp_q.push_back(exp);
    bus_access(1'b0, addr, 32'b0, 4'b0, rd, er);
    chk(tag, rd & mask, exp_q.pop_front());
  endtask

  // Rising-edge to rising-edge distance of rtc_o in cycles (bounded)
  task automatic measure_rtc(output int period);
    logic prev;
    int   cyc;
    int   t0;
    period = -1;
    t0     = -1;
    cyc    = 0;
    prev   = rtc_o;
    for (int i = 0; i < 400; i++) begin
      @(negedge soc_clk);
      cyc++;
      if (!prev && rtc_o) begin
        if (t0 < 0) t0 = cyc;
        else begin
          period = cyc - t0;
          break;
        end
      end
      prev = rtc_o;
    end
  endtask

  task automatic count_pwm(input int cycles, output int high);
    high = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge soc_clk);
      if (fan_pwm_o) high++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] rd;
    logic        er;
    int          p;
    int          hi;

    req          = '0;
    fan_sw_i     = 4'h8;
    boot_mode_i  = 2'b01;
    dram_calib_i = 1'b1;

    // Reset values
    #2;
    chk("rst_ready", {31'b0, rsp.ready}, 32'd0);
    chk("rst_rdata", rsp.rdata, 32'd0);
    chk("rst_error", {31'b0, rsp.error}, 32'd0);
    chk("rst_rtc",   {31'b0, rtc_o}, 32'd0);
    chk("rst_pwm",   {31'b0, fan_pwm_o}, 32'd0);
    chk("rst_boot",  {30'b0, boot_mode_o}, 32'd0);
    repeat (3) @(negedge soc_clk);
    rst_n = 1'b1;

    // Defaults: RTC_HALF=24 -> period 50; FAN_CTRL reads 0x1F
    measure_rtc(p);
    chk("rtc_period_dflt", p, 32'd50);
    read_chk("fan_ctrl_dflt", 48'h08, 32'hFFFF_FFFF, 32'h0000_001F);
    read_chk("rtc_half_dflt", 48'h04, 32'hFFFF_FFFF, 32'd24);
    read_chk("scratch_dflt",  48'h00, 32'hFFFF_FFFF, 32'd0);

    // Switch-selected duty 8 -> 8 of 16 slots of 125 cycles
    count_pwm(2000, hi);
    chk("pwm_sw8_high", hi, 32'd1000);

    // Boot override
    chk("boot_sw", {30'b0, boot_mode_o}, 32'd1);
    bus_write(48'h0C, 32'h6, 4'hF);
    chk("boot_n1_old", {30'b0, boot_mode_o}, 32'd1);
    @(negedge soc_clk);
    chk("boot_n2_ovr", {30'b0, boot_mode_o}, 32'd2);
    bus_write(48'h0C, 32'h2, 4'hF);
    @(negedge soc_clk);
    chk("boot_ovr_off", {30'b0, boot_mode_o}, 32'd1);

    // Handshake: valid held for three cycles, write with wstrb 0011
    @(negedge soc_clk);
    req.valid = 1'b1;
    req.write = 1'b1;
    req.addr  = 48'h00;
    req.wdata = 32'hDEAD_BEEF;
    req.wstrb = 4'b0011;
    @(negedge soc_clk);
    chk("hs_ready_n1", {31'b0, rsp.ready}, 32'd1);
    @(negedge soc_clk);
    chk("hs_ready_n2", {31'b0, rsp.ready}, 32'd0);
    @(negedge soc_clk);
    req = '0;
    repeat (2) @(negedge soc_clk);
    read_chk("scratch_strb", 48'h00, 32'hFFFF_FFFF, 32'h0000_BEEF);

    // RTC reprogram to 0 mid-period: 0 at N+1 then toggles every cycle
    bus_write(48'h04, 32'h0, 4'hF);
    chk("rtc0_n1", {31'b0, rtc_o}, 32'd0);
    @(negedge soc_clk);
    chk("rtc0_n2", {31'b0, rtc_o}, 32'd1);
    @(negedge soc_clk);
    chk("rtc0_n3", {31'b0, rtc_o}, 32'd0);
    @(negedge soc_clk);
    chk("rtc0_n4", {31'b0, rtc_o}, 32'd1);

    // RTC_HALF=5, then rewrite it exactly on the counter match cycle
    bus_write(48'h04, 32'h5, 4'hF);
    repeat (4) @(negedge soc_clk);
    bus_write(48'h04, 32'h5, 4'hF);
    chk("rtc_coll_n1", {31'b0, rtc_o}, 32'd0);
    repeat (5) @(negedge soc_clk);
    chk("rtc_coll_n6", {31'b0, rtc_o}, 32'd0);
    @(negedge soc_clk);
    chk("rtc_coll_n7", {31'b0, rtc_o}, 32'd1);

    // Error path and read-only STATUS (rtc bit masked)
    bus_access(1'b0, 48'h18, 32'b0, 4'b0, rd, er);
    chk("unmap_err",   {31'b0, er}, 32'd1);
    chk("unmap_rdata", rd, 32'hBADC_AB1E);
    read_chk("status_pre", 48'h10, 32'hFFFF_FF7F, 32'h0000_0058);
    bus_access(1'b1, 48'h10, 32'hFFFF_FFFF, 4'hF, rd, er);
    chk("status_wr_err", {31'b0, er}, 32'd0);
    read_chk("status_post", 48'h10, 32'hFFFF_FF7F, 32'h0000_0058);
    bus_access(1'b1, 48'h14, 32'h1234_5678, 4'hF, rd, er);
    chk("unmap_wr_err", {31'b0, er}, 32'd1);
    read_chk("scratch_after_unmap", 48'h00, 32'hFFFF_FFFF, 32'h0000_BEEF);

    // Fan extremes
    bus_write(48'h08, 32'h00, 4'hF);
    repeat (4) @(negedge soc_clk);
    count_pwm(2000, hi);
    chk("pwm_duty0", hi, 32'd0);
    bus_write(48'h08, 32'h0F, 4'hF);
    repeat (4) @(negedge soc_clk);
    count_pwm(2000, hi);
    chk("pwm_duty15", hi, 32'd1875);

    // Asynchronous reset during RESP
    @(negedge soc_clk);
    req.valid = 1'b1;
    req.write = 1'b1;
    req.addr  = 48'h00;
    req.wdata = 32'h1234_5678;
    req.wstrb = 4'hF;
    @(posedge soc_clk);
    #2;
    chk("arst_in_resp", {31'b0, rsp.ready}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'b0, rsp.ready}, 32'd0);
    chk("arst_state", {31'b0, dbg_state}, {31'b0, IDLE});
    req = '0;
    @(negedge soc_clk);
    rst_n = 1'b1;
    read_chk("arst_scratch", 48'h00, 32'hFFFF_FFFF, 32'd0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
